// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one request at a time, drives a byte-addressed big-endian data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned halfword/word accesses instead of masking low ea bits.
module lsu_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h10010000,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_base,
    input  logic [15:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] resp_badaddr,
    output logic        mem_wena,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_choose,
    input  logic [31:0] mem_rdata
);
    localparam int unsigned DW = 32;
    localparam logic [2:0]  OP_LW = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    op_q;
    logic [DW-1:0] ea_q;

    logic [2:0]    size_c;
    logic [DW-1:0] ea_raw_c;
    logic [DW-1:0] ea_c;
    logic [DW-1:0] rel_c;
    logic          range_ok_c;
    logic          align_err_c;
    logic          err_c;
    logic          accept_c;

    // Access size in bytes from the request op
    always_comb begin
        size_c = 3'd4;
        case (req_op)
            3'd0, 3'd1, 3'd5: size_c = 3'd1;
            3'd2, 3'd3, 3'd7: size_c = 3'd2;
            default:          size_c = 3'd4;
        endcase
    end

    assign ea_raw_c = req_base + {{16{req_offset[15]}}, req_offset};

`ifdef LSU_MISALIGN_TRAP_EN
    assign ea_c        = ea_raw_c;
    assign align_err_c = ((size_c == 3'd2) && ea_raw_c[0]) ||
                         ((size_c == 3'd4) && (ea_raw_c[1:0] != 2'b00));
`else
    always_comb begin
        ea_c = ea_raw_c;
        if (size_c == 3'd2) begin
            ea_c[0] = 1'b0;
        end else if (size_c == 3'd4) begin
            ea_c[1:0] = 2'b00;
        end
    end
    assign align_err_c = 1'b0;
`endif

    // Below-base addresses wrap to a huge offset; the 33-bit sum cannot overflow
    assign rel_c      = ea_c - BASE_ADDR;
    assign range_ok_c = (33'(rel_c) + 33'(size_c)) <= 33'(MEM_BYTES);
    assign err_c      = !range_ok_c || align_err_c;
    assign accept_c   = (state == IDLE) && req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus memory-side decode; all memory strobes derive from state only
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_wena   = 1'b0;
        mem_choose = OP_LW;
        mem_raddr  = BASE_ADDR;
        mem_waddr  = BASE_ADDR;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = err_c ? RESP : MEM;
                end
            end
            MEM: begin
                mem_wena   = (op_q >= 3'd5);
                mem_choose = op_q;
                mem_raddr  = ea_q;
                mem_waddr  = ea_q;
                state_nxt  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q         <= OP_LW;
            ea_q         <= BASE_ADDR;
            mem_wdata    <= '0;
            resp_data    <= '0;
            resp_err     <= 1'b0;
            resp_badaddr <= '0;
        end else begin
            if (accept_c) begin
                op_q         <= req_op;
                ea_q         <= ea_c;
                mem_wdata    <= req_wdata;
                resp_data    <= '0;
                resp_err     <= err_c;
                resp_badaddr <= err_c ? ea_c : '0;
            end
            if (state == MEM) begin
                resp_data <= (op_q <= OP_LW) ? mem_rdata : '0;
            end
        end
    end

endmodule
